// File: rtl/axis_frame_gen_pkg.sv
// axis_frame_gen_pkg: frame generator state encoding and the low-aligned tkeep helper
package axis_frame_gen_pkg;
  localparam int KEEP_MAX = 64;
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;
  // kw lanes wide; lanes below `remaining` enabled, so remaining >= kw yields all-ones
  function automatic logic [KEEP_MAX-1:0] keep_mask(input logic [31:0] remaining, input int unsigned kw);
    logic [KEEP_MAX-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < KEEP_MAX; i++) m[i] = (i < kw) && (i < remaining);
    return m;
  endfunction
endpackage

// File: rtl/axis_frame_gen.sv
// axis_frame_gen: emits one AXI-Stream frame per length command; lane bytes count up
// from 0 across the frame and the final beat carries tlast with a low-aligned tkeep.
module axis_frame_gen
  import axis_frame_gen_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int LEN_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LEN_WIDTH-1:0]  s_len_tdata,
  input  logic                  s_len_tvalid,
  output logic                  s_len_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic                  len_err
);
  localparam logic [LEN_WIDTH-1:0] STEP = KEEP_ENABLE ? LEN_WIDTH'(KEEP_WIDTH) : LEN_WIDTH'(1);
  state_t                r_state, w_state_nxt;
  logic [LEN_WIDTH-1:0]  r_rem, r_off, w_rem_nxt, w_off_nxt;
  logic [DATA_WIDTH-1:0] r_tdata, w_data_nxt;
  logic [KEEP_WIDTH-1:0] r_tkeep, w_keep_nxt;
  logic                  r_tlast, r_len_err, w_last_nxt;
  logic                  w_cmd, w_beat, w_last, w_zero, w_load;
  assign w_cmd  = s_len_tvalid && (r_state == IDLE);
  assign w_beat = m_axis_tready && (r_state == SEND);
  assign w_zero = (s_len_tdata == '0);
  assign w_last = (r_rem <= STEP);
  assign w_load = (w_cmd && !w_zero) || (w_beat && !w_last);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  always_comb begin
    w_state_nxt = (w_cmd && !w_zero) ? SEND : (w_beat && w_last) ? IDLE : r_state;
  end
  // Next-beat contents are computed from the post-handshake counters so outputs stay registered
  always_comb begin
    s_len_tready  = (r_state == IDLE);
    m_axis_tvalid = (r_state == SEND);
    busy          = (r_state == SEND);
    m_axis_tdata  = r_tdata;
    m_axis_tkeep  = r_tkeep;
    m_axis_tlast  = r_tlast;
    len_err       = r_len_err;
    w_rem_nxt     = w_cmd ? s_len_tdata : r_rem - STEP;
    w_off_nxt     = w_cmd ? '0 : r_off + STEP;
    w_last_nxt    = (w_rem_nxt <= STEP);
    w_keep_nxt    = KEEP_ENABLE ? KEEP_WIDTH'(keep_mask(32'(w_rem_nxt), KEEP_WIDTH)) : '1;
  end
  generate
    if (KEEP_ENABLE) begin : g_bytes
      for (genvar k = 0; k < KEEP_WIDTH; k++) begin : g_lane
        assign w_data_nxt[8*k +: 8] = w_keep_nxt[k] ? 8'(w_off_nxt + LEN_WIDTH'(k)) : 8'h00;
      end
    end else begin : g_beats
      assign w_data_nxt = DATA_WIDTH'(w_off_nxt);
    end
  endgenerate
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_rem     <= '0;
      r_off     <= '0;
      r_tdata   <= '0;
      r_tkeep   <= '0;
      r_tlast   <= 1'b0;
      r_len_err <= 1'b0;
    end else begin
      r_len_err <= w_cmd && w_zero;
      if (w_load) begin
        r_rem   <= w_rem_nxt;
        r_off   <= w_off_nxt;
        r_tdata <= w_data_nxt;
        r_tkeep <= w_keep_nxt;
        r_tlast <= w_last_nxt;
      end else if (w_beat) begin
        r_tdata <= '0;
        r_tkeep <= '0;
        r_tlast <= 1'b0;
      end
    end
endmodule

// File: tb/tb_axis_frame_gen.sv
// tb_axis_frame_gen: scoreboard bench for the 64-bit byte mode and 8-bit beat mode generators
module tb_axis_frame_gen;
  typedef struct {logic [63:0] data; logic [7:0] keep; logic last;} beat_t;
  typedef struct {int len; int beats; int gap;} frm_t;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [15:0] s_len_tdata, s8_tdata;
  logic        s_len_tvalid, s_len_tready, s8_tvalid, s8_tready;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep, m8_tdata;
  logic        m_tvalid, m_tready, m_tlast, busy, len_err;
  logic        m8_tkeep, m8_tvalid, m8_tlast, busy8, len_err8;
  logic        bp = 1'b0;
  beat_t q[$], q8[$], e, e8;
  frm_t  fq[$], f;
  int n_chk = 0, n_err = 0, cyc = 0, last_cyc = -100, bcnt = 0, acc = 0;
  logic        stalled = 1'b0;
  logic [63:0] held_d;
  logic [8:0]  held_c;

  axis_frame_gen #(.DATA_WIDTH(64)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .s_len_tdata(s_len_tdata), .s_len_tvalid(s_len_tvalid), .s_len_tready(s_len_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .busy(busy), .len_err(len_err));

  axis_frame_gen #(.DATA_WIDTH(8), .KEEP_ENABLE(1'b0)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .s_len_tdata(s8_tdata), .s_len_tvalid(s8_tvalid), .s_len_tready(s8_tready),
    .m_axis_tdata(m8_tdata), .m_axis_tkeep(m8_tkeep), .m_axis_tvalid(m8_tvalid),
    .m_axis_tready(1'b1), .m_axis_tlast(m8_tlast), .busy(busy8), .len_err(len_err8));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_frame(input int len, input int gap);
    beat_t b;
    int nb;
    nb = (len + 7) / 8;
    for (int i = 0; i < nb; i++) begin
      int rem;
      rem = len - 8 * i;
      b.keep = (rem >= 8) ? 8'hFF : 8'(8'hFF >> (8 - rem));
      b.last = (rem <= 8);
      b.data = '0;
      for (int k = 0; k < 8; k++) b.data[8*k +: 8] = b.keep[k] ? 8'(8 * i + k) : 8'h00;
      q.push_back(b);
    end
    fq.push_back('{len, nb, gap});
  endtask

  task automatic cmd(input int len, input int gap);
    bit ok;
    ok = 1'b0;
    s_len_tvalid = 1'b1;
    s_len_tdata  = 16'(len);
    if (len > 0) push_frame(len, gap);
    for (int t = 0; t < 3000 && !ok; t++) begin
      @(negedge clk);
      ok = s_len_tready;
      @(posedge clk);
      #1;
    end
    chk("cmd_accept", 64'(ok), 64'd1);
  endtask

  task automatic cmd8(input int len);
    bit ok;
    beat_t b;
    ok = 1'b0;
    s8_tvalid = 1'b1;
    s8_tdata  = 16'(len);
    for (int i = 0; i < len; i++) begin
      b.data = 64'(i);
      b.keep = 8'h01;
      b.last = (i == len - 1);
      q8.push_back(b);
    end
    for (int t = 0; t < 3000 && !ok; t++) begin
      @(negedge clk);
      ok = s8_tready;
      @(posedge clk);
      #1;
    end
    s8_tvalid = 1'b0;
    chk("cmd8_accept", 64'(ok), 64'd1);
  endtask

  task automatic drain();
    for (int t = 0; t < 3000 && (q.size() > 0 || fq.size() > 0 || q8.size() > 0); t++) @(posedge clk);
    chk("drain", 64'(q.size() + fq.size() + q8.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk);
    #1;
    m_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      bcnt = 0;
      acc = 0;
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_valid", 64'(m_tvalid), 64'd1);
        chk("stall_data", m_tdata, held_d);
        chk("stall_ctl", 64'({m_tlast, m_tkeep}), 64'(held_c));
      end
      stalled = m_tvalid && !m_tready;
      held_d  = m_tdata;
      held_c  = {m_tlast, m_tkeep};
      if (m_tvalid && m_tready) begin
        if (q.size() == 0) chk("extra_beat", 64'd1, 64'd0);
        else begin
          e = q.pop_front();
          if (bcnt == 0 && fq.size() > 0 && fq[0].gap > 0) chk("gap", 64'(cyc - last_cyc), 64'(fq[0].gap));
          chk("beat_data", m_tdata, e.data);
          chk("beat_keep", 64'(m_tkeep), 64'(e.keep));
          chk("beat_last", 64'(m_tlast), 64'(e.last));
          bcnt++;
          acc += $countones(m_tkeep);
          if (m_tlast && fq.size() > 0) begin
            f = fq.pop_front();
            chk("mon_len", 64'(acc), 64'(f.len));
            chk("beats", 64'(bcnt), 64'(f.beats));
            bcnt = 0;
            acc = 0;
          end
        end
        last_cyc = cyc;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && m8_tvalid) begin
      if (q8.size() == 0) chk("extra_beat8", 64'd1, 64'd0);
      else begin
        e8 = q8.pop_front();
        chk("b8_data", 64'(m8_tdata), e8.data);
        chk("b8_keep", 64'(m8_tkeep), 64'(e8.keep[0]));
        chk("b8_last", 64'(m8_tlast), 64'(e8.last));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired n_chk=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    s_len_tvalid = 1'b0;
    s_len_tdata  = '0;
    s8_tvalid    = 1'b0;
    s8_tdata     = '0;
    m_tready     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_tdata", m_tdata, 64'd0);
    chk("rst_tkeep", 64'(m_tkeep), 64'd0);
    chk("rst_tlast", 64'(m_tlast), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_len_err", 64'(len_err), 64'd0);
    chk("rst_tready", 64'(s_len_tready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cmd(20, 0);
    s_len_tvalid = 1'b0;
    chk("first_beat_lat", 64'(m_tvalid), 64'd1);
    chk("busy_send", 64'(busy), 64'd1);
    chk("cmd_rdy_send", 64'(s_len_tready), 64'd0);
    drain();
    cmd(8, 0);
    cmd(1, 2);
    s_len_tvalid = 1'b0;
    drain();
    bp = 1'b1;
    cmd(300, 0);
    s_len_tvalid = 1'b0;
    drain();
    bp = 1'b0;
    cmd(0, 0);
    s_len_tvalid = 1'b0;
    chk("len_err_pulse", 64'(len_err), 64'd1);
    chk("zero_no_beat", 64'(m_tvalid), 64'd0);
    chk("zero_rdy", 64'(s_len_tready), 64'd1);
    @(posedge clk);
    #1;
    chk("len_err_clear", 64'(len_err), 64'd0);
    cmd(5, 0);
    s_len_tvalid = 1'b0;
    drain();
    cmd8(4);
    drain();
    @(posedge clk);
    #1;
    cmd(40, 0);
    s_len_tvalid = 1'b0;
    @(posedge clk);
    #1;
    chk("beat2_valid", 64'(m_tvalid), 64'd1);
    chk("beat2_byte", 64'(m_tdata[7:0]), 64'h08);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_tlast", 64'(m_tlast), 64'd0);
    q.delete();
    fq.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cmd(16, 0);
    s_len_tvalid = 1'b0;
    drain();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/axis_frame_gen.md
# axis_frame_gen

AXI-Stream frame generator: accepts a frame length command and emits one frame of exactly that many bytes on an AXI-Stream master, with a low-aligned partial `tkeep` and `tlast` on the final beat. It is the source-side counterpart of the frame-length monitor. Loopback `m_axis_*` into the monitor: the monitor reports the commanded length. It sits at the head of test and traffic paths as a deterministic packet source.

## Interface
- `DATA_WIDTH`, 64, stream data width; multiple of 8 when `KEEP_ENABLE`=1
- `KEEP_ENABLE`, `DATA_WIDTH>8`, byte-granular `tkeep` on the last beat
- `KEEP_WIDTH`, `DATA_WIDTH/8`, `tkeep` width
- `LEN_WIDTH`, 16, length command width
- `clk` in 1: single clock, all logic on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `s_len_tdata` in `LEN_WIDTH`: frame length; units are bytes if `KEEP_ENABLE`=1, otherwise beats
- `s_len_tvalid` in 1: command valid
- `s_len_tready` out 1: command accepted when high with `s_len_tvalid`
- `m_axis_tdata` out `DATA_WIDTH`: frame payload
- `m_axis_tkeep` out `KEEP_WIDTH`: byte enables
- `m_axis_tvalid` out 1: beat valid
- `m_axis_tready` in 1: downstream ready
- `m_axis_tlast` out 1: final beat of frame
- `busy` out 1: frame in progress
- `len_err` out 1: one-cycle pulse, zero-length command dropped

## Operation
- FSM states:
  - IDLE: `s_len_tready`=1, `m_axis_tvalid`=0.
  - SEND: `s_len_tready`=0, `m_axis_tvalid`=1.
- IDLE transitions on command handshake:
  - Length L=0: stay in IDLE, pulse `len_err` next cycle, emit nothing.
  - L>0: load `remaining`=L and `byte_off`=0, go to SEND.
- SEND, current beat:
  - Beat is last when `remaining` ≤ `KEEP_WIDTH` (bytes mode) or `remaining`==1 (beat mode).
  - `tkeep` on the last beat = all-ones >> (`KEEP_WIDTH` − `remaining`); all-ones on other beats.
  - `tkeep` is tied all-ones when `KEEP_ENABLE`=0.
  - `tlast` is asserted only on the last beat.
- Payload, bytes mode:
  - Byte lane k = (`byte_off`+k)[7:0] for enabled lanes; disabled lanes = 0.
  - `byte_off` counts bytes from the start of the frame, so lane bytes run 0,1,2,…,255,0,… across beats.
- Payload, beat mode: `tdata` = beat index, zero-extended or truncated to `DATA_WIDTH`.
- On each beat handshake (`tvalid`&&`tready`):
  - Not the last beat: `remaining` −= `KEEP_WIDTH` (or −= 1 in beat mode); `byte_off` += `KEEP_WIDTH` (or += 1).
  - Last beat: go to IDLE.
- `busy` = (state==SEND).
- Arithmetic:
  - `remaining` and `byte_off` are `LEN_WIDTH` wide. `byte_off` wraps modulo 2^`LEN_WIDTH` and only its low 8 bits are used.
  - Maximum frame is 2^`LEN_WIDTH`−1 units.
- Outputs are registered. While `tvalid`=1 and `tready`=0, `tdata`/`tkeep`/`tlast` hold stable (AXI-S rule). `tvalid` never drops without a handshake, except on reset.

## Timing
- Reset (async assert, sync release): IDLE, `m_axis_tvalid`=0, `tlast`=0, `tkeep`=0, `tdata`=0, `busy`=0, `len_err`=0, `s_len_tready`=1 (combinational from state).
- Command handshake in cycle N → first beat valid in N+1.
- Throughput: one beat per cycle while `tready`=1.
- Last-beat handshake in cycle M → IDLE in M+1 (`s_len_tready`=1). If a command is accepted at M+1, the next first beat is valid at M+2. The inter-frame gap is one cycle.
- Commands presented during SEND wait (`s_len_tready`=0). There is no queueing.
- Reset mid-frame: `m_axis_tvalid` drops asynchronously. The truncated frame has no `tlast`. Commands in flight are lost.
- L exact multiple of `KEEP_WIDTH`: last beat has full `tkeep`.
- L < `KEEP_WIDTH`: single beat with `tlast` and a partial `tkeep`.

## Structure
- Package `axis_frame_gen_pkg`: state enum (IDLE, SEND) and a function `keep_mask(remaining)` returning the low-aligned `tkeep`. The function is shared with the monitor-side checkers.
- Single flat module. No sub-module is needed.
- Expected size ~150 lines.

## Test plan
- L=20, `DATA_WIDTH`=64, `tready`=1:
  - Three beats.
  - `tkeep` = FF, FF, 0F; `tlast` on beat 3.
  - Bytes 0x00..0x13.
  - Loopback monitor reports 20.
- L=8: one beat, `tkeep`=FF, `tlast`=1. Then L=1: one beat, `tkeep`=01, `tdata`=0x00. Gap between the two frames is exactly one cycle.
- L=300 with random `tready` backpressure:
  - 38 beats; last `tkeep`=0F.
  - Outputs stable while stalled.
  - Byte lane values wrap 0xFF→0x00 at byte 256.
- L=0 → `len_err` pulses one cycle, no beat, `s_len_tready` stays 1. Then L=5 → `tkeep`=1F.
- `KEEP_ENABLE`=0, `DATA_WIDTH`=8, L=4 → four beats with `tdata` 0,1,2,3 and `tlast` on beat 4.
- `rst_n` asserted mid-frame on beat 2 of L=40:
  - `tvalid`=0 immediately, `busy`=0.
  - After release, L=16 produces two full beats starting at byte 0x00.
